// File: rtl/kbd_pkg.sv
// Shared scancode constants and the FIFO entry layout for the keyboard front-end.
package kbd_pkg;

  localparam logic [7:0] PS2_REL = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  localparam int unsigned ENTRY_W = 10;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } kbd_entry_t;

endpackage

// File: rtl/ps2_at2xt.sv
// Combinational AT (scan set 2) to XT (scan set 1) make-code translation.
// Codes with no XT equivalent come back with bit 7 set so they pass through untouched.
module ps2_at2xt (
  input  logic [7:0] at_code,
  output logic [7:0] keyb_xt
);

  always_comb begin
    keyb_xt = {1'b1, at_code[6:0]};
    unique case (at_code)
      8'h01: keyb_xt = 8'h43;  8'h03: keyb_xt = 8'h3F;  8'h04: keyb_xt = 8'h3D;
      8'h05: keyb_xt = 8'h3B;  8'h06: keyb_xt = 8'h3C;  8'h07: keyb_xt = 8'h58;
      8'h09: keyb_xt = 8'h44;  8'h0A: keyb_xt = 8'h42;  8'h0B: keyb_xt = 8'h40;
      8'h0C: keyb_xt = 8'h3E;  8'h0D: keyb_xt = 8'h0F;  8'h0E: keyb_xt = 8'h29;
      8'h11: keyb_xt = 8'h38;  8'h12: keyb_xt = 8'h2A;  8'h14: keyb_xt = 8'h1D;
      8'h15: keyb_xt = 8'h10;  8'h16: keyb_xt = 8'h02;  8'h1A: keyb_xt = 8'h2C;
      8'h1B: keyb_xt = 8'h1F;  8'h1C: keyb_xt = 8'h1E;  8'h1D: keyb_xt = 8'h11;
      8'h1E: keyb_xt = 8'h03;  8'h21: keyb_xt = 8'h2E;  8'h22: keyb_xt = 8'h2D;
      8'h23: keyb_xt = 8'h20;  8'h24: keyb_xt = 8'h12;  8'h25: keyb_xt = 8'h05;
      8'h26: keyb_xt = 8'h04;  8'h29: keyb_xt = 8'h39;  8'h2A: keyb_xt = 8'h2F;
      8'h2B: keyb_xt = 8'h21;  8'h2C: keyb_xt = 8'h14;  8'h2D: keyb_xt = 8'h13;
      8'h2E: keyb_xt = 8'h06;  8'h31: keyb_xt = 8'h31;  8'h32: keyb_xt = 8'h30;
      8'h33: keyb_xt = 8'h23;  8'h34: keyb_xt = 8'h22;  8'h35: keyb_xt = 8'h15;
      8'h36: keyb_xt = 8'h07;  8'h3A: keyb_xt = 8'h32;  8'h3B: keyb_xt = 8'h24;
      8'h3C: keyb_xt = 8'h16;  8'h3D: keyb_xt = 8'h08;  8'h3E: keyb_xt = 8'h09;
      8'h41: keyb_xt = 8'h33;  8'h42: keyb_xt = 8'h25;  8'h43: keyb_xt = 8'h17;
      8'h44: keyb_xt = 8'h18;  8'h45: keyb_xt = 8'h0B;  8'h46: keyb_xt = 8'h0A;
      8'h49: keyb_xt = 8'h34;  8'h4A: keyb_xt = 8'h35;  8'h4B: keyb_xt = 8'h26;
      8'h4C: keyb_xt = 8'h27;  8'h4D: keyb_xt = 8'h19;  8'h4E: keyb_xt = 8'h0C;
      8'h52: keyb_xt = 8'h28;  8'h54: keyb_xt = 8'h1A;  8'h55: keyb_xt = 8'h0D;
      8'h58: keyb_xt = 8'h3A;  8'h59: keyb_xt = 8'h36;  8'h5A: keyb_xt = 8'h1C;
      8'h5B: keyb_xt = 8'h1B;  8'h5D: keyb_xt = 8'h2B;  8'h66: keyb_xt = 8'h0E;
      8'h69: keyb_xt = 8'h4F;  8'h6B: keyb_xt = 8'h4B;  8'h6C: keyb_xt = 8'h47;
      8'h70: keyb_xt = 8'h52;  8'h71: keyb_xt = 8'h53;  8'h72: keyb_xt = 8'h50;
      8'h73: keyb_xt = 8'h4C;  8'h74: keyb_xt = 8'h4D;  8'h75: keyb_xt = 8'h48;
      8'h76: keyb_xt = 8'h01;  8'h77: keyb_xt = 8'h45;  8'h78: keyb_xt = 8'h57;
      8'h79: keyb_xt = 8'h4E;  8'h7A: keyb_xt = 8'h51;  8'h7B: keyb_xt = 8'h4A;
      8'h7C: keyb_xt = 8'h37;  8'h7D: keyb_xt = 8'h49;  8'h7E: keyb_xt = 8'h46;
      8'h83: keyb_xt = 8'h41;
      default: ;
    endcase
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with explicit occupancy count; simultaneous
// write and read are both honoured even when full.
module sync_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 10,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en_i & ~empty_q;
    do_wr    = wr_en_i & (~full_q | do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd)      count_d = count_q + (AW+1)'(1);
    else if (!do_wr && do_rd) count_d = count_q - (AW+1)'(1);
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/ps2_kbd_queue.sv
// Keyboard front-end: F0/E0 prefix tracking, AT->XT formatting and a key-event
// queue between the PS/2 receiver and the CPU.
module ps2_kbd_queue
  import kbd_pkg::*;
#(
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned XT_MODE = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [7:0]    ps2_data,
  input  logic          ps2_data_en,
  input  logic          kb_pop,
  input  logic          kb_ovf_clr,
  output logic [7:0]    kb_ch,
  output logic          kb_rel,
  output logic          kb_ext,
  output logic          kb_hit,
  output logic [AW:0]   kb_count,
  output logic          kb_ovf,
  output logic          kb_tr
);

  logic       rel_q, rel_d;
  logic       ext_q, ext_d;
  logic       ovf_q, ovf_d;
  logic       tr_q, tr_d;
  logic       push;
  logic [7:0] keyb_xt;
  kbd_entry_t entry;
  kbd_entry_t head;
  logic       fifo_full, fifo_empty;

  ps2_at2xt u_at2xt (
    .at_code (ps2_data),
    .keyb_xt (keyb_xt)
  );

  // Prefix flags, entry formatting, overflow and legacy toggle.
  always_comb begin
    rel_d      = rel_q;
    ext_d      = ext_q;
    ovf_d      = ovf_q;
    tr_d       = tr_q;
    push       = 1'b0;
    entry.ext  = ext_q;
    entry.rel  = rel_q;
    entry.code = ps2_data;
    if (XT_MODE != 0) begin
      entry.code = keyb_xt[7] ? keyb_xt : {rel_q, keyb_xt[6:0]};
    end
    if (kb_ovf_clr) ovf_d = 1'b0;
    if (ps2_data_en) begin
      if (ps2_data == PS2_REL) begin
        rel_d = 1'b1;
      end else if (ps2_data == PS2_EXT) begin
        ext_d = 1'b1;
      end else begin
        push  = 1'b1;
        rel_d = 1'b0;
        ext_d = 1'b0;
      end
    end
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    if (push && fifo_full && !kb_pop) ovf_d = 1'b1;
    else if (push)                    tr_d  = ~tr_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rel_q <= 1'b0;
      ext_q <= 1'b0;
      ovf_q <= 1'b0;
      tr_q  <= 1'b0;
    end else begin
      rel_q <= rel_d;
      ext_q <= ext_d;
      ovf_q <= ovf_d;
      tr_q  <= tr_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset_n),
    .wr_en_i   (push),
    .wr_data_i (entry),
    .rd_en_i   (kb_pop),
    .rd_data_o (head),
    .count_o   (kb_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign kb_hit = ~fifo_empty;
  assign kb_ch  = fifo_empty ? 8'h00 : head.code;
  assign kb_rel = ~fifo_empty & head.rel;
  assign kb_ext = ~fifo_empty & head.ext;
  assign kb_ovf = ovf_q;
  assign kb_tr  = tr_q;

endmodule

// File: tb/tb_ps2_kbd_queue.sv
// Directed bench for ps2_kbd_queue: XT instance fully checked, raw-AT instance
// shares stimulus and is checked on the release sequence.
module tb_ps2_kbd_queue;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_data_en = 1'b0;
  logic       kb_pop = 1'b0;
  logic       kb_ovf_clr = 1'b0;

  logic [7:0] kb_ch, r_ch;
  logic       kb_rel, kb_ext, kb_hit, kb_ovf, kb_tr;
  logic       r_rel, r_ext, r_hit, r_ovf, r_tr;
  logic [4:0] kb_count, r_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] at_tbl [17] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                              8'h45, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C};
  logic [7:0] xt_tbl [17] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
                              8'h0B, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};

  always #5 clock = ~clock;

  ps2_kbd_queue #(.DEPTH(16), .XT_MODE(1)) u_dut (
    .clock (clock), .reset_n (reset_n), .ps2_data (ps2_data), .ps2_data_en (ps2_data_en),
    .kb_pop (kb_pop), .kb_ovf_clr (kb_ovf_clr), .kb_ch (kb_ch), .kb_rel (kb_rel),
    .kb_ext (kb_ext), .kb_hit (kb_hit), .kb_count (kb_count), .kb_ovf (kb_ovf), .kb_tr (kb_tr)
  );

  ps2_kbd_queue #(.DEPTH(16), .XT_MODE(0)) u_raw (
    .clock (clock), .reset_n (reset_n), .ps2_data (ps2_data), .ps2_data_en (ps2_data_en),
    .kb_pop (kb_pop), .kb_ovf_clr (kb_ovf_clr), .kb_ch (r_ch), .kb_rel (r_rel),
    .kb_ext (r_ext), .kb_hit (r_hit), .kb_count (r_count), .kb_ovf (r_ovf), .kb_tr (r_tr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; outputs are stable #1 after the closing edge.
  task automatic drive(input logic [7:0] d, input logic en, input logic pop, input logic clr);
    @(posedge clock); #1;
    ps2_data = d; ps2_data_en = en; kb_pop = pop; kb_ovf_clr = clr;
    @(posedge clock); #1;
    ps2_data_en = 1'b0; kb_pop = 1'b0; kb_ovf_clr = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] d);
    drive(d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pop();
    drive(8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic exp_tr;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    chk("rst_hit", kb_hit, 0);
    chk("rst_ch", kb_ch, 8'h00);
    chk("rst_count", kb_count, 0);
    chk("rst_ovf", kb_ovf, 0);
    chk("rst_tr", kb_tr, 0);

    strobe(8'h1C);
    chk("t1_hit", kb_hit, 1);
    chk("t1_ch", kb_ch, 8'h1E);
    chk("t1_rel", kb_rel, 0);
    chk("t1_ext", kb_ext, 0);
    chk("t1_tr", kb_tr, 1);
    pop();
    chk("t1_pop_hit", kb_hit, 0);
    chk("t1_pop_ch", kb_ch, 8'h00);

    strobe(8'hF0);
    chk("t2_prefix_count", kb_count, 0);
    strobe(8'h1C);
    chk("t2_ch", kb_ch, 8'h9E);
    chk("t2_rel", kb_rel, 1);
    chk("t2_count", kb_count, 1);
    pop();

    strobe(8'hE0); strobe(8'hF0); strobe(8'h75);
    chk("t3_ch", kb_ch, 8'hC8);
    chk("t3_ext", kb_ext, 1);
    chk("t3_rel", kb_rel, 1);
    pop();
    strobe(8'h75);
    chk("t3b_ch", kb_ch, 8'h48);
    chk("t3b_ext", kb_ext, 0);
    chk("t3b_rel", kb_rel, 0);
    pop();
    chk("t3_tr", kb_tr, 0);

    exp_tr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      strobe(at_tbl[i]);
      if (i < 16) exp_tr = ~exp_tr;
      chk($sformatf("t4_tr%0d", i), kb_tr, exp_tr);
    end
    chk("t4_count", kb_count, 16);
    chk("t4_ovf", kb_ovf, 1);
    drive(8'h4E, 1'b1, 1'b0, 1'b1);
    chk("t4_ovf_set_wins", kb_ovf, 1);
    chk("t4_count_drop", kb_count, 16);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    chk("t4_ovf_clr", kb_ovf, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t4_drain%0d", i), kb_ch, xt_tbl[i]);
      pop();
    end
    chk("t4_empty", kb_hit, 0);

    for (int i = 0; i < 16; i++) strobe(at_tbl[i]);
    chk("t5_full", kb_count, 16);
    drive(at_tbl[16], 1'b1, 1'b1, 1'b0);
    chk("t5_count", kb_count, 16);
    chk("t5_ovf", kb_ovf, 0);
    chk("t5_head", kb_ch, xt_tbl[1]);
    for (int i = 0; i < 15; i++) pop();
    chk("t5_tail", kb_ch, xt_tbl[16]);
    chk("t5_tail_count", kb_count, 1);
    pop();

    strobe(8'hF0);
    @(posedge clock); #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    chk("t6_rst_count", kb_count, 0);
    strobe(8'h1C);
    chk("t6_ch", kb_ch, 8'h1E);
    chk("t6_rel", kb_rel, 0);
    pop();
    strobe(8'hF0); strobe(8'h1C);
    chk("t6_raw_ch", r_ch, 8'h1C);
    chk("t6_raw_rel", r_rel, 1);
    chk("t6_raw_count", r_count, 1);
    chk("t6_xt_ch", kb_ch, 8'h9E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
